// File: rtl/ah_snoop_hazard_gate_if.sv
// ah_snoop_hazard_gate_if: request, FIFO snoop and forward channels of the hazard gate
interface ah_snoop_hazard_gate_if #(parameter int DATA_W = 32);
  logic [DATA_W-1:0] req_data, sdata, out_data;
  logic req_valid, req_ready, svalid, smatch, out_valid, out_ready, out_hazard;
  modport master (
    input  req_data, req_valid, smatch, out_ready,
    output req_ready, sdata, svalid, out_data, out_valid, out_hazard
  );
  modport slave (
    output req_data, req_valid, smatch, out_ready,
    input  req_ready, sdata, svalid, out_data, out_valid, out_hazard
  );
endinterface

// File: rtl/ah_snoop_hazard_gate.sv
// ah_snoop_hazard_gate: holds one request, re-snoops the write FIFO until its key is clear or retries run out, then forwards it
module ah_snoop_hazard_gate #(
  parameter int DATA_W    = 32,
  parameter int SNOOP_W   = 16,
  parameter int BACKOFF   = 4,
  parameter int MAX_RETRY = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  ah_snoop_hazard_gate_if.master bus,
  output logic [15:0]            hit_count
);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int BW = $clog2(BACKOFF) + 1;
  typedef enum logic [1:0] {S_IDLE, S_SNOOP, S_BACKOFF, S_ISSUE} state_t;
  state_t            state;
  logic [DATA_W-1:0] hold;
  logic [RW-1:0]     retry_cnt;
  logic [BW-1:0]     bo_cnt;
  logic              last_try;
  assign last_try      = 32'(retry_cnt) + 32'd1 >= 32'(MAX_RETRY);
  assign bus.req_ready = state == S_IDLE;
  assign bus.svalid    = state == S_SNOOP;
  assign bus.out_valid = state == S_ISSUE;
  assign bus.out_data  = hold;
  assign bus.sdata     = {{(DATA_W-SNOOP_W){1'b0}}, hold[SNOOP_W-1:0]};
  // smatch is only sampled here, so it never reaches an output combinationally
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state          <= S_IDLE;
      hold           <= '0;
      retry_cnt      <= '0;
      bo_cnt         <= '0;
      bus.out_hazard <= 1'b0;
      hit_count      <= '0;
    end else begin
      case (state)
        S_IDLE:
          if (bus.req_valid) begin
            hold      <= bus.req_data;
            retry_cnt <= '0;
            state     <= S_SNOOP;
          end
        S_SNOOP: begin
          if (bus.smatch && retry_cnt == '0 && hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
          if (!bus.smatch) begin
            bus.out_hazard <= 1'b0;
            state          <= S_ISSUE;
          end else if (last_try) begin
            bus.out_hazard <= 1'b1;
            state          <= S_ISSUE;
          end else begin
            retry_cnt <= retry_cnt + 1'b1;
            bo_cnt    <= BW'(BACKOFF - 1);
            state     <= S_BACKOFF;
          end
        end
        S_BACKOFF:
          if (bo_cnt == '0) state <= S_SNOOP;
          else bo_cnt <= bo_cnt - 1'b1;
        default:
          if (bus.out_ready) state <= S_IDLE;
      endcase
    end
endmodule

// File: doc/ah_snoop_hazard_gate.md
# ah_snoop_hazard_gate

Read-side hazard gate for the snoopable write FIFO. It sits on the request path and, for each request, drives the FIFO's snoop port (`sdata`/`svalid`) and samples `smatch`. A request is forwarded downstream only once no pending FIFO entry matches its key. If the match persists for `MAX_RETRY` snoops, the request is forwarded anyway with a hazard flag.

## Interface
Parameters:
- `DATA_W`, 32: request and data width.
- `SNOOP_W`, 16: key width; key = `req_data[SNOOP_W-1:0]`.
- `BACKOFF`, 4: idle cycles between a matching snoop and the next re-snoop (≥1).
- `MAX_RETRY`, 8: matching snoops tolerated before a forced issue (≥1).

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `req_data`  in  DATA_W  incoming request.
- `req_valid`  in  1  request valid.
- `req_ready`  out  1  gate can accept a request.
- `sdata`  out  DATA_W  snoop key to FIFO: {zeros, held key}.
- `svalid`  out  1  snoop query valid.
- `smatch`  in  1  FIFO match result, combinational, same cycle as `svalid`.
- `out_data`  out  DATA_W  forwarded request.
- `out_valid`  out  1  forwarded request valid.
- `out_ready`  in  1  downstream accepts.
- `out_hazard`  out  1  request forced out after `MAX_RETRY` matches; qualified by `out_valid`.
- `hit_count`  out  16  saturating count of requests that saw ≥1 match.

## Operation
- FSM states: IDLE, SNOOP, BACKOFF, ISSUE. All outputs are registered or decoded from state; there is no combinational path from `smatch` to any output.
- IDLE: `req_ready`=1.
  - On `req_valid`: capture `req_data` into the hold register, clear `retry_cnt`, go to SNOOP.
- SNOOP: `svalid`=1, `sdata`={(DATA_W-SNOOP_W)'0, hold[SNOOP_W-1:0]}. Sample `smatch` at the clock edge.
  - `smatch`=0: go to ISSUE, `out_hazard`=0.
  - `smatch`=1 and `retry_cnt`+1 < `MAX_RETRY`: `retry_cnt`++, load `bo_cnt`=`BACKOFF`-1, go to BACKOFF.
  - `smatch`=1 and `retry_cnt`+1 == `MAX_RETRY`: go to ISSUE with `out_hazard`=1.
  - First matching snoop of a request: `hit_count`++ (saturates at 16'hFFFF).
- BACKOFF: `svalid`=0.
  - `bo_cnt`==0: go to SNOOP.
  - Otherwise `bo_cnt`--.
- ISSUE: `out_valid`=1, `out_data`=hold.
  - On `out_ready`: go to IDLE.
  - `out_data` and `out_hazard` are held stable while `out_valid`=1 and `out_ready`=0.
- `req_ready`=0 in every state except IDLE. There is one request in flight; no queuing.
- `retry_cnt` width is clog2(`MAX_RETRY`+1). `bo_cnt` width is clog2(`BACKOFF`)+1.
- `smatch` is ignored outside SNOOP.

## Timing
- Reset values: state IDLE, `req_ready`=1, `svalid`=0, `sdata`=0, `out_valid`=0, `out_data`=0, `out_hazard`=0, `hit_count`=0, `retry_cnt`=0, `bo_cnt`=0.
- Accept at edge 0, no match: `svalid`=1 in cycle 1, `out_valid`=1 in cycle 2. Minimum latency is 2 cycles; `req_ready` reasserts the cycle after the `out_ready` handshake.
- A match at a snoop in cycle t gives BACKOFF for cycles t+1..t+`BACKOFF`, then a re-snoop in cycle t+`BACKOFF`+1.
- Snoop k of a request occurs in cycle 1+(k-1)(`BACKOFF`+1).
- Back-to-back requests: minimum issue interval is 3 cycles (IDLE, SNOOP, ISSUE).
- Reset asserted mid-operation: immediate return to reset values. The held request is dropped and `hit_count` is cleared.
- `req_valid` asserted during a non-IDLE state is not accepted; the upstream must hold it.

## Test plan
- No hazard: req_data=32'hDEAD_0042, `smatch`=0 → `svalid` cycle 1 with `sdata`=32'h0000_0042; `out_valid` cycle 2 with `out_data`=32'hDEAD_0042, `out_hazard`=0; `hit_count`=0.
- Single match: `smatch`=1 at the cycle-1 snoop only → `svalid` low cycles 2-5, re-snoop cycle 6, `out_valid` cycle 7, `out_hazard`=0, `hit_count`=1.
- Persistent match, defaults: `smatch` held 1 → 8 snoops in cycles 1,6,...,36; `out_valid` cycle 37 with `out_hazard`=1; `hit_count`=1.
- Backpressure: `out_ready`=0 for 5 cycles in ISSUE → `out_data`/`out_hazard` stable, `req_ready`=0 throughout; handshake in cycle 7, `req_ready`=1 in cycle 8.
- Reset in BACKOFF: `rstn` low in cycle 3 of the single-match case → `svalid`=0, `out_valid`=0, `req_ready`=1, `hit_count`=0 immediately; a new request after release completes with 2-cycle latency.
- `hit_count` saturation: preload by forcing to 16'hFFFE, then 3 matching requests → `hit_count` ends at 16'hFFFF.
